// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM generator and its fade scheduler.
// Provides channel/duty widths, the duty type, the scheduler FSM states
// and the duty clamp helper.
package pwm_pkg;

    localparam int unsigned NUM_CH   = 8;
    localparam int unsigned CH_W     = 3;
    localparam int unsigned DUTY_W   = 7;
    localparam int unsigned MAX_DUTY = 99;

    typedef logic [DUTY_W-1:0] duty_t;
    typedef logic [CH_W-1:0]   ch_t;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } sched_state_t;

    // Limit a requested duty to the generator's legal range.
    function automatic duty_t clamp_duty(input duty_t d);
        return (d > duty_t'(MAX_DUTY)) ? duty_t'(MAX_DUTY) : d;
    endfunction

endpackage

// File: rtl/pwm_tick_divider.sv
// Free-running ramp tick generator.
// Ports:
//   clk  - system clock
//   rst  - synchronous, active-high reset
//   tick - one-cycle pulse, high while the counter sits at TICK_DIV-1
module pwm_tick_divider #(
    parameter int unsigned TICK_DIV = 1000
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [CNT_W-1:0] r_cnt;
    logic             r_tick;

    // Counter wraps at TICK_DIV-1; the pulse is decoded one count early so it
    // is registered yet aligned with the terminal count.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt  <= '0;
            r_tick <= 1'b0;
        end else begin
            if (r_cnt == CNT_W'(TICK_DIV - 1)) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            r_tick <= (r_cnt == CNT_W'(TICK_DIV - 2));
        end
    end

    assign tick = r_tick;

endmodule

// File: rtl/pwm_fade_scheduler.sv
// Fade scheduler: accepts per-channel target/step commands and, once per ramp
// tick, walks all channels moving each current duty toward its target,
// emitting at most one generator write per clock.
// Ports:
//   clk, rst                 - clock, synchronous active-high reset
//   cmd_valid/cmd_ready      - command handshake (accepted only in IDLE)
//   cmd_ch/target/step       - channel, requested duty (clamped), step (0 = jump)
//   duty_in/channel_sel      - write data/address to the PWM generator
//   load_duty                - one-cycle write strobe
//   busy                     - per-channel "still fading" flags
module pwm_fade_scheduler
    import pwm_pkg::*;
#(
    parameter int unsigned TICK_DIV = 1000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [CH_W-1:0]   cmd_ch,
    input  logic [DUTY_W-1:0] cmd_target,
    input  logic [DUTY_W-1:0] cmd_step,
    output logic [DUTY_W-1:0] duty_in,
    output logic [CH_W-1:0]   channel_sel,
    output logic              load_duty,
    output logic [NUM_CH-1:0] busy
);

    sched_state_t      r_state;
    sched_state_t      w_state_nxt;
    ch_t               r_idx;
    ch_t               w_idx_nxt;
    logic              w_accept;
    logic              w_scan_start;
    logic              w_ready_nxt;

    duty_t             r_cur  [NUM_CH];
    duty_t             r_tgt  [NUM_CH];
    duty_t             r_step [NUM_CH];
    logic [NUM_CH-1:0] r_imm;
    duty_t             w_cur_nxt  [NUM_CH];
    duty_t             w_tgt_nxt  [NUM_CH];
    duty_t             w_step_nxt [NUM_CH];
    logic [NUM_CH-1:0] w_imm_nxt;
    logic [NUM_CH-1:0] w_busy_nxt;

    logic              r_tick_pending;
    logic              w_tick;

    duty_t             w_sel_cur;
    duty_t             w_sel_tgt;
    duty_t             w_sel_step;
    logic              w_sel_imm;
    duty_t             w_diff;
    duty_t             w_new_cur;
    logic              w_write;

    logic              r_cmd_ready;
    logic              r_load_duty;
    duty_t             r_duty_in;
    ch_t               r_channel_sel;
    logic [NUM_CH-1:0] r_busy;

    pwm_tick_divider #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_div (
        .clk  (clk),
        .rst  (rst),
        .tick (w_tick)
    );

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state: an immediate command forces a scan in its own accept cycle
    always_comb begin
        w_state_nxt  = r_state;
        w_idx_nxt    = r_idx;
        w_accept     = 1'b0;
        w_scan_start = 1'b0;
        case (r_state)
            IDLE: begin
                w_accept = cmd_valid && r_cmd_ready;
                if (r_tick_pending || (w_accept && (cmd_step == '0))) begin
                    w_state_nxt  = SCAN;
                    w_idx_nxt    = '0;
                    w_scan_start = 1'b1;
                end
            end
            SCAN: begin
                if (r_idx == CH_W'(NUM_CH - 1)) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_idx_nxt = r_idx + CH_W'(1);
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
        w_ready_nxt = (w_state_nxt == IDLE);
    end

    assign w_sel_cur  = r_cur[r_idx];
    assign w_sel_tgt  = r_tgt[r_idx];
    assign w_sel_step = r_step[r_idx];
    assign w_sel_imm  = r_imm[r_idx];

    // One ramp step for the scanned channel; min() keeps it from overshooting
    always_comb begin
        w_diff    = '0;
        w_new_cur = w_sel_cur;
        if (w_sel_imm) begin
            w_new_cur = w_sel_tgt;
        end else if (w_sel_cur < w_sel_tgt) begin
            w_diff    = w_sel_tgt - w_sel_cur;
            w_new_cur = w_sel_cur + ((w_sel_step < w_diff) ? w_sel_step : w_diff);
        end else if (w_sel_cur > w_sel_tgt) begin
            w_diff    = w_sel_cur - w_sel_tgt;
            w_new_cur = w_sel_cur - ((w_sel_step < w_diff) ? w_sel_step : w_diff);
        end
        w_write = (r_state == SCAN) && (w_new_cur != w_sel_cur);
    end

    // Register-file next values: command writes in IDLE, ramp update in SCAN
    always_comb begin
        w_cur_nxt  = r_cur;
        w_tgt_nxt  = r_tgt;
        w_step_nxt = r_step;
        w_imm_nxt  = r_imm;
        if (w_accept) begin
            w_tgt_nxt[cmd_ch]  = clamp_duty(cmd_target);
            w_step_nxt[cmd_ch] = cmd_step;
            if (cmd_step == '0) begin
                w_imm_nxt[cmd_ch] = 1'b1;
            end
        end
        if (r_state == SCAN) begin
            w_cur_nxt[r_idx] = w_new_cur;
            w_imm_nxt[r_idx] = 1'b0;
        end
        for (int i = 0; i < NUM_CH; i++) begin
            w_busy_nxt[i] = (w_cur_nxt[i] != w_tgt_nxt[i]) || w_imm_nxt[i];
        end
    end

    // Datapath and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_cur[i]  <= '0;
                r_tgt[i]  <= '0;
                r_step[i] <= '0;
            end
            r_imm          <= '0;
            r_idx          <= '0;
            r_tick_pending <= 1'b0;
            r_cmd_ready    <= 1'b0;
            r_load_duty    <= 1'b0;
            r_duty_in      <= '0;
            r_channel_sel  <= '0;
            r_busy         <= '0;
        end else begin
            r_cur  <= w_cur_nxt;
            r_tgt  <= w_tgt_nxt;
            r_step <= w_step_nxt;
            r_imm  <= w_imm_nxt;
            r_idx  <= w_idx_nxt;
            // A new tick wins over the clear so it is never lost
            if (w_tick) begin
                r_tick_pending <= 1'b1;
            end else if (w_scan_start) begin
                r_tick_pending <= 1'b0;
            end
            r_cmd_ready <= w_ready_nxt;
            r_load_duty <= w_write;
            if (w_write) begin
                r_duty_in     <= w_new_cur;
                r_channel_sel <= r_idx;
            end
            r_busy <= w_busy_nxt;
        end
    end

    assign cmd_ready   = r_cmd_ready;
    assign load_duty   = r_load_duty;
    assign duty_in     = r_duty_in;
    assign channel_sel = r_channel_sel;
    assign busy        = r_busy;

endmodule

// File: tb/tb_pwm_fade_scheduler.sv
// Self-checking bench for pwm_fade_scheduler with a short ramp tick.
module tb_pwm_fade_scheduler;

    localparam int TB_TICK = 16;
    localparam int NCH     = int'(pwm_pkg::NUM_CH);
    localparam int MAXD    = int'(pwm_pkg::MAX_DUTY);

    logic       clk;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_ch;
    logic [6:0] cmd_target;
    logic [6:0] cmd_step;
    logic [6:0] duty_in;
    logic [2:0] channel_sel;
    logic       load_duty;
    logic [7:0] busy;

    pwm_fade_scheduler #(
        .TICK_DIV (TB_TICK)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_ch      (cmd_ch),
        .cmd_target  (cmd_target),
        .cmd_step    (cmd_step),
        .duty_in     (duty_in),
        .channel_sel (channel_sel),
        .load_duty   (load_duty),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: channel state plus tick/scan bookkeeping in plain ints
    int m_cur [NCH];
    int m_tgt [NCH];
    int m_step[NCH];
    bit m_imm [NCH];
    int m_cnt;
    bit m_pend;
    bit m_scan;
    int m_pos;
    bit m_ready;
    bit m_load;
    int m_ch;
    int m_duty;
    bit m_rst;
    int cyc = 0;

    typedef struct {
        int edge_n;
        int ch;
        int duty;
    } wr_t;
    wr_t wlog[$];

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    task automatic model_edge();
        bit tick;
        bit start;
        int i;
        int nv;
        int c;
        if (rst) begin
            for (int k = 0; k < NCH; k++) begin
                m_cur[k] = 0; m_tgt[k] = 0; m_step[k] = 0; m_imm[k] = 0;
            end
            m_cnt = 0; m_pend = 0; m_scan = 0; m_pos = 0;
            m_ready = 0; m_load = 0; m_ch = 0; m_duty = 0; m_rst = 1;
        end else begin
            tick   = (m_cnt == TB_TICK - 1);
            start  = 0;
            m_rst  = 0;
            m_cnt  = (m_cnt + 1) % TB_TICK;
            m_load = 0;
            if (m_scan) begin
                i  = m_pos;
                nv = m_cur[i];
                if (m_imm[i]) begin
                    nv = m_tgt[i];
                    m_imm[i] = 0;
                end else if (m_cur[i] < m_tgt[i]) begin
                    nv = m_cur[i] + imin(m_step[i], m_tgt[i] - m_cur[i]);
                end else if (m_cur[i] > m_tgt[i]) begin
                    nv = m_cur[i] - imin(m_step[i], m_cur[i] - m_tgt[i]);
                end
                if (nv != m_cur[i]) begin
                    m_load = 1; m_ch = i; m_duty = nv;
                end
                m_cur[i] = nv;
                m_pos++;
                if (m_pos == NCH) m_scan = 0;
            end else begin
                if (m_ready && cmd_valid) begin
                    c = int'(cmd_ch);
                    m_tgt[c]  = imin(int'(cmd_target), MAXD);
                    m_step[c] = int'(cmd_step);
                    if (cmd_step == 7'd0) begin
                        m_imm[c] = 1;
                        start = 1;
                    end
                end
                if (m_pend || start) begin
                    m_scan = 1; m_pos = 0; m_pend = 0;
                end
            end
            if (tick) m_pend = 1;
            m_ready = !m_scan;
        end
    endtask

    task automatic compare();
        int bv;
        bv = 0;
        for (int k = 0; k < NCH; k++) begin
            if ((m_cur[k] != m_tgt[k]) || m_imm[k]) bv = bv | (1 << k);
        end
        check_eq("cmd_ready", int'(cmd_ready), int'(m_ready));
        check_eq("load_duty", int'(load_duty), int'(m_load));
        check_eq("busy", int'(busy), bv);
        if (m_load || m_rst) begin
            check_eq("channel_sel", int'(channel_sel), m_ch);
            check_eq("duty_in", int'(duty_in), m_duty);
        end
    endtask

    always @(posedge clk) begin
        cyc++;
        model_edge();
        #1;
        compare();
        if (load_duty === 1'b1) wlog.push_back('{cyc, int'(channel_sel), int'(duty_in)});
    end

    task automatic send_cmd(input int ch, input int tgt, input int step,
                            output int waits, output int acc_edge);
        @(negedge clk);
        cmd_valid  = 1'b1;
        cmd_ch     = 3'(ch);
        cmd_target = 7'(tgt);
        cmd_step   = 7'(step);
        waits = 0;
        while (cmd_ready !== 1'b1 && waits < 300) begin
            waits++;
            @(negedge clk);
        end
        if (waits >= 300) check_eq("cmd_accept_timeout", waits, 0);
        @(posedge clk);
        #2;
        acc_edge = cyc;
    endtask

    task automatic bus_idle();
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic check_log(input string tag, input int idx, input int ch, input int duty);
        if (idx < wlog.size()) begin
            check_eq({tag, "_ch"}, wlog[idx].ch, ch);
            check_eq({tag, "_duty"}, wlog[idx].duty, duty);
        end else begin
            check_eq({tag, "_missing"}, wlog.size(), idx + 1);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w, ta, tb2, found, others;
        rst = 1'b1; cmd_valid = 1'b0; cmd_ch = '0; cmd_target = '0; cmd_step = '0;
        repeat (3) @(posedge clk);
        #2;
        check_eq("rst_load", int'(load_duty), 0);
        check_eq("rst_ready", int'(cmd_ready), 0);
        check_eq("rst_busy", int'(busy), 0);

        // Reset release and quiet period
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #2;
        check_eq("ready_after_rst", int'(cmd_ready), 1);
        wlog.delete();
        repeat (100) @(posedge clk);
        #2;
        check_eq("quiet_writes", wlog.size(), 0);

        // Immediate jump on channel 2
        wlog.delete();
        send_cmd(2, 40, 0, w, ta);
        check_eq("imm_busy_set", int'(busy[2]), 1);
        bus_idle();
        repeat (20) @(posedge clk);
        #2;
        check_eq("imm_count", wlog.size(), 1);
        check_log("imm", 0, 2, 40);
        if (wlog.size() > 0) check_eq("imm_latency", wlog[0].edge_n - ta, 3);
        check_eq("imm_busy_clr", int'(busy[2]), 0);

        // Ramp up channel 0
        wlog.delete();
        send_cmd(0, 20, 7, w, ta);
        bus_idle();
        repeat (5 * TB_TICK) @(posedge clk);
        #2;
        check_eq("ramp_count", wlog.size(), 3);
        check_log("ramp0", 0, 0, 7);
        check_log("ramp1", 1, 0, 14);
        check_log("ramp2", 2, 0, 20);
        if (wlog.size() >= 3) check_eq("ramp_spacing", wlog[2].edge_n - wlog[1].edge_n, TB_TICK);
        check_eq("ramp_busy_clr", int'(busy[0]), 0);

        // Ramp down and clamp on channel 5
        wlog.delete();
        send_cmd(5, 60, 0, w, ta);  bus_idle(); repeat (20) @(posedge clk);
        send_cmd(5, 120, 0, w, ta); bus_idle(); repeat (20) @(posedge clk);
        send_cmd(5, 0, 50, w, ta);  bus_idle(); repeat (4 * TB_TICK) @(posedge clk);
        #2;
        check_eq("down_count", wlog.size(), 4);
        check_log("down0", 0, 5, 60);
        check_log("down1", 1, 5, 99);
        check_log("down2", 2, 5, 49);
        check_log("down3", 3, 5, 0);

        // Handshake held through a scan, then two channels ramping together
        send_cmd(3, 10, 0, w, ta);
        send_cmd(1, 30, 5, w, tb2);
        check_eq("ready_low_cycles", w, 8);
        send_cmd(6, 30, 5, w, tb2);
        bus_idle();
        wlog.delete();
        repeat (3 * TB_TICK) @(posedge clk);
        #2;
        found = 0; others = 0;
        foreach (wlog[a]) begin
            if (wlog[a].ch != 1 && wlog[a].ch != 6) others++;
            if (wlog[a].ch == 6) begin
                foreach (wlog[b]) begin
                    if (wlog[b].ch == 1 && wlog[b].edge_n == wlog[a].edge_n - 5) found = 1;
                end
            end
        end
        check_eq("pair_spacing", found, 1);
        check_eq("pair_others", others, 0);

        // Reset in the middle of a fade
        send_cmd(4, 90, 3, w, ta);
        bus_idle();
        repeat (40) @(posedge clk);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #2;
        check_eq("midrst_load", int'(load_duty), 0);
        check_eq("midrst_busy", int'(busy), 0);
        check_eq("midrst_ready", int'(cmd_ready), 0);
        @(negedge clk); rst = 1'b0;
        wlog.delete();
        repeat (100) @(posedge clk);
        #2;
        check_eq("midrst_quiet", wlog.size(), 0);

        // Randomized commands against the model
        for (int k = 0; k < 60; k++) begin
            int gap, ch, tgt, sel, step;
            gap = int'($urandom_range(0, 30));
            repeat (gap) @(negedge clk);
            ch  = int'($urandom_range(0, 7));
            tgt = int'($urandom_range(0, 127));
            sel = int'($urandom_range(0, 3));
            if (sel == 0)      step = 0;
            else if (sel == 1) step = int'($urandom_range(1, 4));
            else               step = int'($urandom_range(1, 127));
            send_cmd(ch, tgt, step, w, ta);
            bus_idle();
            if (k == 30) begin
                @(negedge clk); rst = 1'b1;
                @(negedge clk); rst = 1'b0;
            end
        end
        repeat (300) @(posedge clk);
        #2;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
